// File: rtl/calculate_exp_series.sv
// calculate_exp_series: streams T(0)=base, T(k+1)=round(T(k)*ratio >> FRAC_W) with
// saturation, one term per ready/valid handshake, multiply pipelined MUL_LAT deep.
module calculate_exp_series #(
    parameter int DATA_W  = 18,
    parameter int FRAC_W  = 12,
    parameter int ADDR_W  = 9,
    parameter int MUL_LAT = 2
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [DATA_W-1:0] iBase,
    input  logic [DATA_W-1:0] iRatio,
    input  logic [ADDR_W:0]   iCount,
    input  logic              iStart,
    input  logic              iAbort,
    input  logic              iReady,
    output logic [DATA_W-1:0] oData,
    output logic [ADDR_W-1:0] oAddr,
    output logic              oValid,
    output logic              oDone,
    output logic              oBusy,
    output logic              oSat
);
    typedef enum logic [1:0] {IDLE, EMIT, MUL, DONE} state_t;
    localparam int CW = MUL_LAT > 1 ? $clog2(MUL_LAT) : 1;
    localparam logic [2*DATA_W:0] HALF = (2*DATA_W+1)'(1) << (FRAC_W - 1);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d, ratio_q, ratio_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                sat_q, sat_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*DATA_W-1:0] prod;
    logic [2*DATA_W:0]   rnd, shr;
    logic [DATA_W:0]     mul_res;
    logic [DATA_W:0]     pipe_q [MUL_LAT];
    logic                last, mul_end;

    // Product is recomputed every cycle; data_q is frozen through MUL, so the
    // pipeline tail holds the next term exactly when MUL ends.
    assign prod    = {{DATA_W{1'b0}}, data_q} * {{DATA_W{1'b0}}, ratio_q};
    assign rnd     = {1'b0, prod} + HALF;
    assign shr     = rnd >> FRAC_W;
    assign mul_res = |shr[2*DATA_W:DATA_W] ? {1'b1, {DATA_W{1'b1}}} : {1'b0, shr[DATA_W-1:0]};
    assign last    = {1'b0, addr_q} == count_q - 1'b1;
    assign mul_end = cnt_q == CW'(MUL_LAT - 1);

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ratio_d = ratio_q;
        addr_d  = addr_q;
        count_d = count_q;
        sat_d   = sat_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (iStart) begin
                state_d = iCount == '0 ? DONE : EMIT;
                data_d  = iBase;
                ratio_d = iRatio;
                count_d = iCount;
                addr_d  = '0;
                sat_d   = 1'b0;
            end
            EMIT: if (iAbort) state_d = IDLE;
                  else if (iReady) begin
                      state_d = last ? DONE : MUL;
                      cnt_d   = '0;
                  end
            MUL: if (iAbort) state_d = IDLE;
                 else if (mul_end) begin
                     state_d = EMIT;
                     data_d  = pipe_q[MUL_LAT-1][DATA_W-1:0];
                     sat_d   = sat_q | pipe_q[MUL_LAT-1][DATA_W];
                     addr_d  = addr_q + 1'b1;
                 end else cnt_d = cnt_q + 1'b1;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            data_q  <= '0;
            ratio_q <= '0;
            addr_q  <= '0;
            count_q <= '0;
            sat_q   <= 1'b0;
            cnt_q   <= '0;
            for (int i = 0; i < MUL_LAT; i++) pipe_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            ratio_q   <= ratio_d;
            addr_q    <= addr_d;
            count_q   <= count_d;
            sat_q     <= sat_d;
            cnt_q     <= cnt_d;
            pipe_q[0] <= mul_res;
            for (int i = 1; i < MUL_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign oData  = data_q;
    assign oAddr  = addr_q;
    assign oValid = state_q == EMIT;
    assign oDone  = state_q == DONE;
    assign oBusy  = state_q != IDLE;
    assign oSat   = sat_q;
endmodule

// File: doc/calculate_exp_series.md
CALCULATE_EXP_SERIES -- requirements
Module: calculate_exp_series

Interface
REQ-001 Parameter DATA_W, default 18: unsigned fixed-point sample width.
REQ-002 Parameter FRAC_W, default 12: fractional bits of iBase, iRatio and oData.
REQ-003 Parameter ADDR_W, default 9: address and count width; maximum series length is 2^ADDR_W.
REQ-004 Parameter MUL_LAT, default 2: multiplier pipeline depth in cycles, minimum 1.
REQ-005 CLK  in  1  sole clock; all state SHALL change on the rising edge.
REQ-006 RST_N  in  1  asynchronous, active-low reset.
REQ-007 iBase  in  DATA_W  first term, e.g. exp(mu).
REQ-008 iRatio  in  DATA_W  per-step multiplier, e.g. exp(step).
REQ-009 iCount  in  ADDR_W+1  number of terms, 0..2^ADDR_W.
REQ-010 iStart  in  1  one-cycle start pulse.
REQ-011 iAbort  in  1  cancels the run in progress.
REQ-012 iReady  in  1  downstream accepts the current term.
REQ-013 oData  out  DATA_W  current term.
REQ-014 oAddr  out  ADDR_W  index k of the current term.
REQ-015 oValid  out  1  oData/oAddr valid.
REQ-016 oDone  out  1  one-cycle pulse after the last term is accepted.
REQ-017 oBusy  out  1  high in any state other than IDLE.
REQ-018 oSat  out  1  sticky saturation flag for the current run.

Function
REQ-019 The block SHALL emit T(0)=iBase and T(k+1)=round((T(k)*iRatio) >> FRAC_W), as unsigned values, for k=0..iCount-1.
REQ-020 The product SHALL be 2*DATA_W bits wide, with no intermediate truncation.
REQ-021 Rounding SHALL be half-up: add 2^(FRAC_W-1) before the shift.
REQ-022 If a rounded result exceeds 2^DATA_W-1, the term SHALL be 2^DATA_W-1 and oSat SHALL set, remaining set until the next accepted iStart.
REQ-023 The FSM SHALL have the states IDLE, EMIT, MUL and DONE.
REQ-024 In IDLE, on iStart=1 with iCount>0: latch iBase, iRatio and iCount, clear oSat, set k=0, and go to EMIT the next cycle with oValid=1, oData=iBase and oAddr=0.
REQ-025 In IDLE, on iStart=1 with iCount=0: go to DONE directly and pulse oDone, with no term emitted.
REQ-026 In EMIT, oValid=1, and oData/oAddr SHALL hold stable while iReady=0.
REQ-027 In EMIT, a handshake (oValid&iReady) with k=count-1 SHALL go to DONE.
REQ-028 In EMIT, any other handshake SHALL go to MUL, with oValid=0 the next cycle.
REQ-029 MUL SHALL last exactly MUL_LAT cycles, then enter EMIT with k+1 and the new term, so consecutive terms are at most one per MUL_LAT+1 cycles.
REQ-030 DONE SHALL last one cycle with oDone=1 and oValid=0, then go to IDLE.
REQ-031 iStart SHALL be ignored outside IDLE; input changes after the latch SHALL not affect the run.
REQ-032 iAbort=1 in EMIT, MUL or DONE SHALL go to IDLE the next cycle, with oValid=0 and no oDone (a DONE-cycle oDone already asserted stands).
REQ-033 iAbort together with a handshake SHALL take priority: the term counts as consumed, and no further terms or oDone follow.
REQ-034 iAbort and iStart together in IDLE: iStart SHALL win.
REQ-035 A count of 2^ADDR_W SHALL emit oAddr 0..2^ADDR_W-1 with no wrap before DONE.

Reset
REQ-036 RST_N=0 SHALL immediately force IDLE, oValid=0, oDone=0, oBusy=0, oSat=0, oData=0 and oAddr=0, regardless of CLK.
REQ-037 After RST_N deasserts, the block SHALL accept iStart on the first rising edge.
REQ-038 Reset mid-run SHALL discard the run with no oDone.

Verification
REQ-039 Geometric run: defaults, iBase=4096, iRatio=8192, iCount=4, iReady=1 -> terms 4096, 8192, 16384, 32768 at oAddr 0..3; terms MUL_LAT+1 cycles apart; oDone one cycle after the last handshake; oSat=0.
REQ-040 Saturation run: iBase=4096, iRatio=8192, iCount=8 -> terms k0..k5 = 4096..131072, k6=262143, k7=262143; oSat=1 from k6 onward.
REQ-041 Rounding run: iBase=3, iRatio=2048, iCount=4 -> terms 3, 2, 1, 1.
REQ-042 Backpressure: iReady=0 for 5 cycles during k=1 -> oData=8192 and oAddr=1 held stable; sequence otherwise identical to REQ-039.
REQ-043 Control edges:
- iCount=0 -> oDone pulse with no oValid.
- iAbort during MUL of k=2 -> IDLE, no further terms, no oDone.
- iStart while busy -> ignored.
- RST_N low mid-run -> all outputs 0 asynchronously.
